// File: rtl/contadores_pkg.sv
// Shared types and default widths for the counter readout sequencer.
package contadores_pkg;

  localparam int CNT_AW = 6;
  localparam int CNT_CW = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } scan_state_t;

  typedef struct packed {
    logic [CNT_AW-1:0] adress;
    logic [CNT_CW-1:0] count;
  } scan_rec_t;

endpackage

// File: rtl/contadores_scan.sv
// Counter RAM readout sequencer: sweeps every address, streams {address, count}
// records, optionally clears each entry. Optional build macro: CONTADORES_SKIP_ZERO_EN.
module contadores_scan
  import contadores_pkg::*;
#(
  parameter int AW = CNT_AW,
  parameter int CW = CNT_CW
) (
  input  logic             clk,
  input  logic             gen_reset_n,
  input  logic             start,
  input  logic             clear_on_read,
  output logic [AW-1:0]    ram_adress,
  output logic             ram_count_read,
  output logic             ram_write_enable,
  output logic             ram_count_reset,
  input  logic [CW-1:0]    ram_count_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_adress,
  output logic [CW-1:0]    out_count,
  output logic             busy,
  output logic             done,
  output logic [AW+CW-1:0] total,
  output logic [CW-1:0]    max_count
);

  localparam logic [AW-1:0] ADDR_LAST = '1;

  scan_state_t       state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              clr_q, clr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     max_q, max_d;
  logic [AW+CW-1:0]  total_q, total_d;
  logic              advance;
  logic              skip_zero;

  function automatic logic [CW-1:0] max_sel(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef CONTADORES_SKIP_ZERO_EN
  assign skip_zero = (ram_count_out == '0);
`else
  assign skip_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    total_d = total_q;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          total_d = '0;
          max_d   = '0;
          clr_d   = clear_on_read;
          state_d = READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        cnt_d   = ram_count_out;
        total_d = total_q + {{AW{1'b0}}, ram_count_out};
        max_d   = max_sel(max_q, ram_count_out);
        if (skip_zero) advance = 1'b1;
        else           state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (clr_q) state_d = CLEAR;
          else       advance = 1'b1;
        end
      end
      CLEAR: advance = 1'b1;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Step to the next entry; the sweep stops at the last address, never wraps
    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        state_d = DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = READ;
      end
    end
  end

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      clr_q   <= 1'b0;
      cnt_q   <= '0;
      max_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      total_q <= total_d;
    end
  end

  // Outputs decode straight from state so a reset zeroes them immediately
  always_comb begin
    ram_adress       = addr_q;
    ram_count_read   = (state_q == READ);
    ram_write_enable = (state_q == CLEAR);
    ram_count_reset  = (state_q == CLEAR);
    out_valid        = (state_q == SEND);
    out_adress       = (state_q == SEND) ? addr_q : '0;
    out_count        = (state_q == SEND) ? cnt_q : '0;
    busy             = (state_q != IDLE);
    done             = (state_q == DONE);
    total            = total_q;
    max_count        = max_q;
  end

endmodule

// File: tb/tb_contadores_scan.sv
// Self-checking bench for contadores_scan with a behavioural counter RAM.
module tb_contadores_scan;

  localparam int AW = 6;
  localparam int CW = 4;
  localparam int N  = 1 << AW;

`ifdef CONTADORES_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
  localparam int RECS_SPEC = 2;
  localparam int RECS_ZERO = 0;
`else
  localparam bit SKIP = 1'b0;
  localparam int RECS_SPEC = 64;
  localparam int RECS_ZERO = 64;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             gen_reset_n, start, clear_on_read, out_ready;
  logic [AW-1:0]    ram_adress, out_adress;
  logic             ram_count_read, ram_write_enable, ram_count_reset;
  logic             out_valid, busy, done;
  logic [CW-1:0]    ram_count_out, out_count, max_count;
  logic [AW+CW-1:0] total;

  contadores_scan dut (
    .clk(clk), .gen_reset_n(gen_reset_n), .start(start), .clear_on_read(clear_on_read),
    .ram_adress(ram_adress), .ram_count_read(ram_count_read),
    .ram_write_enable(ram_write_enable), .ram_count_reset(ram_count_reset),
    .ram_count_out(ram_count_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_adress(out_adress), .out_count(out_count), .busy(busy), .done(done),
    .total(total), .max_count(max_count)
  );

  // Counter RAM: 1-cycle read latency, clear on write+reset, bulk preload port
  logic [CW-1:0] mem [N];
  logic [CW-1:0] load_img [N];
  logic          load_req;
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= load_img[i];
    end else if (busy) begin
      if (ram_count_read) ram_count_out <= mem[ram_adress];
      if (ram_write_enable && ram_count_reset) mem[ram_adress] <= '0;
    end
  end

  typedef struct { int a; int c; } rec_t;
  typedef struct {
    bit    load;
    bit    clr;
    int    stall_at;
    int    restart_at;
    int    exp_total;
    int    exp_max;
    int    exp_recs;
    string name;
  } vec_t;

  int model_mem [N];
  int passed = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (rnd) model_mem[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
      else     model_mem[i] = (i == 1) ? 3 : (i == 2) ? 2 : 0;
      load_img[i] = model_mem[i][CW-1:0];
    end
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic do_sweep(input bit clr, input int stall_at, input int restart_at,
                          input int exp_total, input int exp_max, input int exp_recs,
                          input string tag);
    rec_t expq[$];
    rec_t got[$];
    int m_total = 0, m_max = 0, busy_exp = 1, clr_exp = 0;
    int busy_n = 0, done_n = 0, clr_n = 0, cyc = 0, bad = 0, stable_bad = 0, idle_bad = 0;
    bit finished = 0, stalled = 0, restarted = 0;

    // Reference: every address in order, zero counts dropped only in skip mode
    for (int a = 0; a < N; a++) begin
      m_total += model_mem[a];
      if (model_mem[a] > m_max) m_max = model_mem[a];
      if (SKIP && model_mem[a] == 0) begin
        busy_exp += 2;
      end else begin
        expq.push_back('{a, model_mem[a]});
        busy_exp += clr ? 4 : 3;
        if (clr) clr_exp++;
      end
    end
    if (stall_at >= 0) busy_exp += 7;
    if (exp_total < 0) exp_total = m_total;
    if (exp_max < 0)   exp_max = m_max;
    if (exp_recs < 0)  exp_recs = expq.size();

    clear_on_read = clr;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    clear_on_read = 1'b0;

    while (!finished && cyc < 1500) begin
      if (stall_at >= 0 && !stalled && out_valid && int'(out_adress) == stall_at) begin
        stalled = 1;
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
          busy_n += int'(busy);
          if (!out_valid || int'(out_adress) != stall_at || int'(out_count) != model_mem[stall_at]
              || ram_count_read || ram_write_enable || ram_count_reset) stable_bad++;
          tick();
          cyc++;
        end
        out_ready = 1'b1;
      end
      if (restart_at >= 0 && !restarted && out_valid && int'(out_adress) == restart_at) begin
        restarted = 1;
        start = 1'b1;
        clear_on_read = 1'b1;
      end
      busy_n += int'(busy);
      done_n += int'(done);
      if (ram_write_enable && ram_count_reset) clr_n++;
      if (out_valid && out_ready) got.push_back('{int'(out_adress), int'(out_count)});
      if (done) finished = 1;
      tick();
      start = 1'b0;
      clear_on_read = 1'b0;
      cyc++;
    end

    chk({tag, " finished"}, finished, 1);
    if (busy) idle_bad++;
    tick();
    if (busy) idle_bad++;
    chk({tag, " idle_after"}, idle_bad, 0);

    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i].a != expq[i].a || got[i].c != expq[i].c) bad++;
    chk({tag, " rec_count"}, got.size(), exp_recs);
    chk({tag, " rec_model_count"}, got.size(), expq.size());
    chk({tag, " rec_mismatch"}, bad, 0);
    chk({tag, " first_addr"}, (got.size() > 0) ? got[0].a : -1, (expq.size() > 0) ? expq[0].a : -1);
    chk({tag, " total"}, total, exp_total);
    chk({tag, " max_count"}, max_count, exp_max);
    chk({tag, " done_pulses"}, done_n, 1);
    chk({tag, " clear_pulses"}, clr_n, clr_exp);
    chk({tag, " busy_cycles"}, busy_n, busy_exp);
    if (stall_at >= 0) chk({tag, " stall_stable"}, stable_bad, 0);

    if (clr) foreach (expq[i]) model_mem[expq[i].a] = 0;
  endtask

  vec_t vecs [4];

  initial begin
    int w;
    vecs[0] = '{1'b1, 1'b0, -1, -1, 5, 3, RECS_SPEC, "plain"};
    vecs[1] = '{1'b1, 1'b0,  2, 10, 5, 3, RECS_SPEC, "stall_restart"};
    vecs[2] = '{1'b1, 1'b1, -1, -1, 5, 3, RECS_SPEC, "clear"};
    vecs[3] = '{1'b0, 1'b0, -1, -1, 0, 0, RECS_ZERO, "after_clear"};

    gen_reset_n = 1'b0;
    start = 1'b0;
    clear_on_read = 1'b0;
    out_ready = 1'b0;
    load_req = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        {ram_adress, ram_count_read, ram_write_enable, ram_count_reset, out_valid,
         out_adress, out_count, busy, done, total, max_count}, 0);
    @(negedge clk);
    gen_reset_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) load_ram(1'b0);
      do_sweep(vecs[v].clr, vecs[v].stall_at, vecs[v].restart_at,
               vecs[v].exp_total, vecs[v].exp_max, vecs[v].exp_recs, vecs[v].name);
    end

    // Asynchronous reset while a record is waiting in SEND
    load_ram(1'b0);
    clear_on_read = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!(out_valid && int'(out_adress) == (SKIP ? 2 : 5)) && w < 300) begin
      tick();
      w++;
    end
    chk("rst_mid_reached_send", w < 300, 1);
    #2;
    gen_reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {ram_adress, ram_count_read, ram_write_enable, ram_count_reset, out_valid,
         out_adress, out_count, busy, done, total, max_count}, 0);
    @(negedge clk);
    gen_reset_n = 1'b1;
    tick();
    do_sweep(1'b0, -1, -1, 5, 3, RECS_SPEC, "after_rst");

    for (int r = 0; r < 4; r++) begin
      load_ram(1'b1);
      do_sweep(1'($urandom_range(0, 1)), -1, -1, -1, -1, -1, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/contadores_scan.md
# contadores_scan

Readout sequencer that sits directly downstream of the counter RAM bank. On a start pulse it sweeps every counter address, reads each count, and streams `{address, count}` records out over a valid/ready handshake. It can optionally clear each counter after its record is accepted. It also accumulates the total and maximum count of the sweep, and owns the RAM read/clear port for the duration of the scan.

## Interface
- `AW`, 6, counter address width; the sweep covers 2^AW entries.
- `CW`, 4, counter data width.

- `clk`  in  1  clock, rising edge.
- `gen_reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a sweep; ignored unless the FSM is in IDLE.
- `clear_on_read`  in  1  sampled on `start`; when 1, each entry is cleared after its record is accepted.
- `ram_adress`  out  AW  counter address driven to the RAM.
- `ram_count_read`  out  1  read strobe to the RAM.
- `ram_write_enable`  out  1  write strobe; used only together with `ram_count_reset`.
- `ram_count_reset`  out  1  clears the addressed counter.
- `ram_count_out`  in  CW  count returned by the RAM, one cycle after the read.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  consumer accepts the record.
- `out_adress`  out  AW  address of the record.
- `out_count`  out  CW  count of the record.
- `busy`  out  1  high in every state except IDLE; the event source must not drive the RAM while it is high.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `total`  out  AW+CW  sum of all counts read in the last sweep.
- `max_count`  out  CW  largest count read in the last sweep.

## Operation
- FSM states: IDLE, READ, WAIT, SEND, CLEAR, DONE.
- IDLE
  - On `start`: `addr <= 0`, `total <= 0`, `max_count <= 0`.
  - Latch `clear_on_read` into `clr_q`, then go to READ.
- READ: drive `ram_adress = addr` and `ram_count_read = 1`, then go to WAIT.
- WAIT
  - Capture `ram_count_out` into `cnt_q`.
  - `total <= total + ram_count_out`, zero-extended; with AW+CW bits this cannot overflow.
  - `max_count <= max(max_count, ram_count_out)`, then go to SEND.
- SEND
  - `out_valid = 1`, `out_adress = addr`, `out_count = cnt_q`; all three hold stable until accepted.
  - On `out_valid && out_ready`: go to CLEAR if `clr_q`, else advance.
- CLEAR: `ram_adress = addr`, `ram_write_enable = 1`, `ram_count_reset = 1` for exactly one cycle, then advance.
- Advance
  - If `addr == 2^AW-1`, go to DONE.
  - Otherwise `addr <= addr + 1` and go to READ. There is no wrap-around within a sweep.
- DONE: `done = 1` for one cycle, then go to IDLE.
- `total` and `max_count` hold their values until the next `start`.
- RAM outputs are 0 in every state other than those listed above. `ram_adress` holds `addr` throughout.
- `start` while busy is ignored; no queuing.
- Asynchronous reset mid-sweep:
  - FSM returns to IDLE and all registers and outputs go to 0.
  - A partially cleared RAM is left as is; the next sweep starts again at address 0.

## Timing
- Reset values: `ram_*` = 0, `out_valid` = 0, `out_adress` = 0, `out_count` = 0, `busy` = 0, `done` = 0, `total` = 0, `max_count` = 0.
- `start` at edge N: `busy` = 1 and READ at N+1; `out_valid` = 1 at N+3.
- Per entry with `out_ready` held at 1:
  - 3 cycles without clear (READ, WAIT, SEND).
  - 4 cycles with clear.
- Full sweep with `out_ready` = 1 and no clear: 3·2^AW + 1 cycles from the first READ to the `done` pulse.
- `out_ready` low stalls SEND indefinitely with no change to any output.
- RAM read latency is fixed at 1 cycle.

## Configuration
- `CONTADORES_SKIP_ZERO_EN` defined:
  - In WAIT, an entry whose count is 0 goes straight to advance. No SEND and no CLEAR are issued for it.
  - It still counts toward `total` (adds 0).
- Undefined: every address is emitted, including zero counts.

## Structure
- Package `contadores_pkg`:
  - FSM state enum `scan_state_t`.
  - Default widths `CNT_AW = 6`, `CNT_CW = 4`.
  - Record struct `scan_rec_t {adress, count}`.
- No sub-module is required. The FSM and datapath live in one module, instantiated next to the counter RAM with a 2:1 mux on the RAM port selected by `busy`.

## Test plan
- Reset asserted mid-SEND at address 5 → all outputs 0 immediately; the next `start` emits address 0 first.
- RAM preloaded with count 3 at address 1, 2 at address 2, 0 elsewhere, `clear_on_read = 0`, `out_ready = 1` → 64 records, `total = 5`, `max_count = 3`, `done` pulse 193 cycles after the first READ.
- Same preload with `clear_on_read = 1` → one `ram_count_reset` pulse per address; a second sweep reports `total = 0`.
- `out_ready` held low for 7 cycles at address 2 → `out_adress = 2` and `out_count = 2` stable for all 7 cycles; no RAM strobes during the stall.
- `start` pulsed again at address 10 → ignored; exactly one `done` pulse.
- With `CONTADORES_SKIP_ZERO_EN` and the same preload → exactly 2 records (addresses 1 and 2), `total = 5`.
